// File: rtl/serial_bit_source_pkg.sv
// Shared types and helpers for the serial bit source.
package serial_bit_source_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter width for a count of n states; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_bit_source_if.sv
// Word-level valid/ready handshake feeding the serializer.
interface serial_bit_source_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/serial_bit_source_bit_period_ticker.sv
// DIV-cycle prescaler marking the first and last clock of each bit period.
module serial_bit_source_bit_period_ticker
  import serial_bit_source_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic period_first,
  output logic period_last
);
  localparam int unsigned   CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // Count clocks within a bit period; restart on reset or on a fresh word load
  always_ff @(posedge clk) begin
    if (reset || load) begin
      div_cnt <= '0;
    end else if (run) begin
      div_cnt <= period_last ? '0 : div_cnt + CW'(1);
    end
  end

  assign period_first = (div_cnt == '0);
  assign period_last  = (div_cnt == LAST);

endmodule

// File: rtl/serial_bit_source.sv
// Parallel-in/serial-out word serializer with a one-word hold buffer so
// consecutive words stream with no idle bit between them.
module serial_bit_source
  import serial_bit_source_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0,
  parameter int unsigned DIV       = 1
) (
  input  logic                clk,
  input  logic                reset,
  serial_bit_source_if.slave  in_if,
  output logic                serial_out,
  output logic                bit_valid,
  output logic                frame_start,
  output logic                busy
);
  localparam int unsigned   BW       = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] shifter, shifter_next;
  logic [WIDTH-1:0] hold, hold_next;
  logic             hold_full, hold_full_next;
  logic [BW-1:0]    bit_cnt, bit_cnt_next;
  logic             serial_next, bit_valid_next, frame_start_next, busy_next;
  logic             handshake, word_end, load_en;
  logic [WIDTH-1:0] load_word;
  logic             period_first, period_last;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign in_if.data_ready = !hold_full && !reset;
  assign handshake        = in_if.data_valid && in_if.data_ready;
  assign word_end         = (state == ST_SHIFT) && period_last && (bit_cnt == LAST_BIT);

  serial_bit_source_bit_period_ticker #(
    .DIV (DIV)
  ) u_ticker (
    .clk          (clk),
    .reset        (reset),
    .load         (load_en),
    .run          (state == ST_SHIFT),
    .period_first (period_first),
    .period_last  (period_last)
  );

  // Next-state and next-output decode; a word load (from idle, from hold, or
  // bypassed from the input at a word boundary) is applied after the case.
  always_comb begin
    state_next       = state;
    shifter_next     = shifter;
    hold_next        = hold;
    hold_full_next   = hold_full;
    bit_cnt_next     = bit_cnt;
    serial_next      = serial_out;
    bit_valid_next   = 1'b0;
    frame_start_next = 1'b0;
    busy_next        = busy;
    load_en          = 1'b0;
    load_word        = in_if.data_in;

    unique case (state)
      ST_IDLE: begin
        if (handshake) load_en = 1'b1;
      end
      ST_SHIFT: begin
        if (handshake && !word_end) begin
          hold_next      = in_if.data_in;
          hold_full_next = 1'b1;
        end
        if (period_last) begin
          if (bit_cnt == LAST_BIT) begin
            if (hold_full) begin
              load_en        = 1'b1;
              load_word      = hold;
              hold_full_next = 1'b0;
            end else if (handshake) begin
              load_en = 1'b1;
            end else begin
              state_next  = ST_IDLE;
              serial_next = IDLE_BIT;
              busy_next   = 1'b0;
            end
          end else begin
            shifter_next   = shift_word(shifter);
            serial_next    = first_bit(shift_word(shifter));
            bit_cnt_next   = bit_cnt + BW'(1);
            bit_valid_next = 1'b1;
          end
        end
      end
    endcase

    if (load_en) begin
      state_next       = ST_SHIFT;
      shifter_next     = load_word;
      serial_next      = first_bit(load_word);
      bit_cnt_next     = '0;
      bit_valid_next   = 1'b1;
      frame_start_next = 1'b1;
      busy_next        = 1'b1;
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      shifter     <= '0;
      hold        <= '0;
      hold_full   <= 1'b0;
      bit_cnt     <= '0;
      serial_out  <= IDLE_BIT;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      shifter     <= shifter_next;
      hold        <= hold_next;
      hold_full   <= hold_full_next;
      bit_cnt     <= bit_cnt_next;
      serial_out  <= serial_next;
      bit_valid   <= bit_valid_next;
      frame_start <= frame_start_next;
      busy        <= busy_next;
    end
  end

  // bit_valid must coincide with the prescaler sitting on a period's first clock
  always_ff @(posedge clk) begin
    if (!reset && bit_valid) assert (period_first);
  end

endmodule

// File: tb/tb_serial_bit_source.sv
// Self-checking bench: DUT a (MSB first, DIV=1), DUT b (LSB first, DIV=3).
module tb_serial_bit_source;

  typedef struct {
    logic b;
    logic fs;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] seq_msb;  // transmission order, seq[7] sent first
    logic [7:0] seq_lsb;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a_so, a_bv, a_fs, a_busy;
  logic b_so, b_bv, b_fs, b_busy;

  int checks = 0;
  int passes = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   b_since = 0;
  logic b_prev_busy = 1'b0;
  logic b_last = 1'b0;
  vec_t vecs[6];

  always #5 clk = ~clk;

  serial_bit_source_if #(.WIDTH(8)) a_if ();
  serial_bit_source_if #(.WIDTH(8)) b_if ();

  serial_bit_source #(
    .WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .DIV(1)
  ) dut_a (
    .clk(clk), .reset(reset), .in_if(a_if),
    .serial_out(a_so), .bit_valid(a_bv), .frame_start(a_fs), .busy(a_busy)
  );

  serial_bit_source #(
    .WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .DIV(3)
  ) dut_b (
    .clk(clk), .reset(reset), .in_if(b_if),
    .serial_out(b_so), .bit_valid(b_bv), .frame_start(b_fs), .busy(b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // DUT a scoreboard: with DIV=1 a bit is valid exactly when one is pending
  always @(negedge clk) begin
    if (!reset) begin
      check("a_stream", {31'b0, a_bv}, {31'b0, q_a.size() != 0});
      check("a_bv_vs_busy", {31'b0, a_bv}, {31'b0, a_busy});
      if (a_bv) begin
        if (q_a.size() != 0) begin
          ea = q_a.pop_front();
          check("a_serial_out", {31'b0, a_so}, {31'b0, ea.b});
          check("a_frame_start", {31'b0, a_fs}, {31'b0, ea.fs});
        end
      end else begin
        check("a_idle_level", {31'b0, a_so}, 32'd0);
        check("a_idle_frame_start", {31'b0, a_fs}, 32'd0);
      end
    end
  end

  // DUT b scoreboard: each bit held exactly 3 clocks, bit_valid on the first
  always @(negedge clk) begin
    if (reset) begin
      b_prev_busy = 1'b0;
      b_since     = 0;
    end else begin
      if (b_bv) begin
        if (b_prev_busy) check("b_period_len", b_since, 2);
        b_since = 0;
        if (q_b.size() == 0) begin
          check("b_unexpected_bit", {31'b0, b_bv}, 32'd0);
        end else begin
          eb = q_b.pop_front();
          check("b_serial_out", {31'b0, b_so}, {31'b0, eb.b});
          check("b_frame_start", {31'b0, b_fs}, {31'b0, eb.fs});
        end
        b_last = b_so;
      end else begin
        check("b_fs_without_bv", {31'b0, b_fs}, 32'd0);
        if (b_busy) begin
          b_since++;
          check("b_hold_level", {31'b0, b_so}, {31'b0, b_last});
          check("b_period_overrun", {31'b0, b_since <= 2}, 32'd1);
        end else begin
          check("b_idle_level", {31'b0, b_so}, 32'd0);
        end
      end
      b_prev_busy = b_busy;
    end
  end

  // Offer a word just before an edge where ready is high; queue its bits
  task automatic send(input bit sel, input logic [7:0] w, input logic [7:0] seq);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      #3;
      if (sel ? b_if.data_ready : a_if.data_ready) begin
        for (int i = 7; i >= 0; i--) begin
          if (sel) q_b.push_back('{b: seq[i], fs: (i == 7)});
          else     q_a.push_back('{b: seq[i], fs: (i == 7)});
        end
        if (sel) begin b_if.data_in = w; b_if.data_valid = 1'b1; end
        else     begin a_if.data_in = w; a_if.data_valid = 1'b1; end
        @(posedge clk);
        #1;
        a_if.data_valid = 1'b0;
        b_if.data_valid = 1'b0;
        done = 1'b1;
      end
    end
    check("send_accepted", {31'b0, done}, 32'd1);
  endtask

  task automatic wait_idle(input bit sel);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      #2;
      if (sel ? (q_b.size() == 0 && !b_busy) : (q_a.size() == 0 && !a_busy)) done = 1'b1;
    end
    check("drain", {31'b0, done}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    a_if.data_in = '0; a_if.data_valid = 1'b0;
    b_if.data_in = '0; b_if.data_valid = 1'b0;
    vecs[0] = '{8'hAA, 8'b10101010, 8'b01010101};
    vecs[1] = '{8'h01, 8'b00000001, 8'b10000000};
    vecs[2] = '{8'hD5, 8'b11010101, 8'b10101011};
    vecs[3] = '{8'h3C, 8'b00111100, 8'b00111100};
    vecs[4] = '{8'hF0, 8'b11110000, 8'b00001111};
    vecs[5] = '{8'h81, 8'b10000001, 8'b10000001};

    // T1: reset held for three clocks
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_serial_out", {31'b0, a_so}, 32'd0);
      check("rst_busy", {31'b0, a_busy}, 32'd0);
      check("rst_bit_valid", {31'b0, a_bv}, 32'd0);
      check("rst_data_ready", {31'b0, a_if.data_ready}, 32'd0);
      check("rst_b_ready", {31'b0, b_if.data_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("ready_after_reset", {31'b0, a_if.data_ready}, 32'd1);
    check("b_ready_after_reset", {31'b0, b_if.data_ready}, 32'd1);

    // T2/T4: single words through both configurations
    for (int v = 0; v < 6; v++) begin
      send(1'b0, vecs[v].data, vecs[v].seq_msb);
      wait_idle(1'b0);
      send(1'b1, vecs[v].data, vecs[v].seq_lsb);
      wait_idle(1'b1);
    end

    // T3: second word offered while the first is shifting
    send(1'b0, 8'hAA, 8'b10101010);
    send(1'b0, 8'hD5, 8'b11010101);
    check("t3_ready_low_hold_full", {31'b0, a_if.data_ready}, 32'd0);
    repeat (7) @(negedge clk);
    check("t3_ready_low_last_bit", {31'b0, a_if.data_ready}, 32'd0);
    @(negedge clk);
    check("t3_ready_after_hold_drain", {31'b0, a_if.data_ready}, 32'd1);
    wait_idle(1'b0);

    // T5: bypass handshake exactly on the last-bit edge
    send(1'b0, 8'hFF, 8'b11111111);
    repeat (7) @(negedge clk);
    send(1'b0, 8'h55, 8'b01010101);
    check("t5_frame_start", {31'b0, a_fs}, 32'd1);
    check("t5_first_bit", {31'b0, a_so}, 32'd0);
    check("t5_busy", {31'b0, a_busy}, 32'd1);
    wait_idle(1'b0);

    // T6: reset at bit 3 with a word waiting in hold
    send(1'b0, 8'hAA, 8'b10101010);
    send(1'b0, 8'h0F, 8'b00001111);
    repeat (3) @(negedge clk);
    #3;
    reset = 1'b1;
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    check("t6_serial_out", {31'b0, a_so}, 32'd0);
    check("t6_busy", {31'b0, a_busy}, 32'd0);
    check("t6_bit_valid", {31'b0, a_bv}, 32'd0);
    check("t6_ready_in_reset", {31'b0, a_if.data_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("t6_no_resume", {31'b0, a_busy}, 32'd0);
    check("t6_ready_after", {31'b0, a_if.data_ready}, 32'd1);

    check("a_queue_empty", q_a.size(), 0);
    check("b_queue_empty", q_b.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
